vid_timing_monitor: RTL
=======================

VID_TIMING_MONITOR -- requirements
Module: vid_timing_monitor

Interface
REQ-001 SHALL have parameter EXP_HA, default 1920, expected active pixels per line.
REQ-002 SHALL have parameter EXP_VA, default 1080, expected active lines per frame.
REQ-003 SHALL have parameter STABLE_FRAMES, default 4, consecutive matching frames required for lock (range 1..15).
REQ-004 SHALL have parameter CW, default 12, width of all measurement counters and outputs.
REQ-005 SHALL have port vin_clk_i, input, 1, pixel clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port vs_i, input, 1, vertical sync, active-high, pre-registered upstream.
REQ-008 SHALL have port hs_i, input, 1, horizontal sync, active-high, pre-registered upstream.
REQ-009 SHALL have port de_i, input, 1, data enable, pre-registered upstream.
REQ-010 SHALL have port h_active_o, output, CW, DE-high cycles per line from the last completed frame.
REQ-011 SHALL have port v_active_o, output, CW, lines containing DE in the last completed frame.
REQ-012 SHALL have port h_total_o, output, CW, cycles between consecutive hs_i rising edges.
REQ-013 SHALL have port frame_done_o, output, 1, one-cycle pulse when the outputs update.
REQ-014 SHALL have port locked_o, output, 1, geometry stable and equal to EXP_HA x EXP_VA.
REQ-015 SHALL have port err_o, output, 1, sticky error: overflow or inconsistent line length; cleared only by reset.

Function
REQ-016 SHALL keep one-cycle-delayed copies vs_q, hs_q and de_q; a rise is x_i=1 with x_q=0, a fall is x_i=0 with x_q=1.
REQ-017 SHALL hold h_cnt counting cycles since the last hs rise; on hs rise, h_cnt is captured into h_tot_m and reset to 1.
REQ-018 SHALL hold de_cnt counting de_i=1 cycles within the current line; on de fall, de_cnt is captured into line_len and then cleared.
REQ-019 SHALL, on de fall, increment line counter l_cnt if this is the first DE run since the last hs rise.
REQ-020 SHALL, on de fall, set flag inc if line_len is nonzero and differs from the previous line_len in the frame.
REQ-021 SHALL saturate every counter at 2^CW-1; reaching saturation sets err_o.
REQ-022 SHALL use an FSM with states SEARCH, MEASURE, VERIFY and LOCKED; reset enters SEARCH.
REQ-023 SHALL, in SEARCH, clear all internal counters and move to MEASURE on the first vs rise, without a frame_done_o pulse.
REQ-024 SHALL, on every vs rise while in MEASURE, VERIFY or LOCKED, end the frame and, one cycle later, update h_active_o from line_len, v_active_o from l_cnt and h_total_o from h_tot_m, pulse frame_done_o, and clear l_cnt and inc.
REQ-025 SHALL define a frame as matching when it has no inc, h_active equals EXP_HA and v_active equals EXP_VA.
REQ-026 SHALL make these transitions at frame end:
- MEASURE -> VERIFY with match_cnt=1 if matching, else stay in MEASURE.
- VERIFY -> LOCKED when match_cnt reaches STABLE_FRAMES; a non-matching frame returns to MEASURE with match_cnt=0.
- LOCKED -> MEASURE on a non-matching frame.
REQ-027 SHALL drive locked_o high only in LOCKED; locked_o changes in the same cycle as the frame_done_o pulse.
REQ-028 SHALL set err_o if inc occurs in any frame; err_o does not affect the FSM except through the match rule.
REQ-029 SHALL, if vs rise and de fall occur in the same cycle, count the de fall into the ending frame first.
REQ-030 SHALL drop to SEARCH if no vs rise occurs for 2^(2*CW) cycles, forcing locked_o low with no frame_done_o pulse.

Reset
REQ-031 SHALL, while rst_n is low, force all outputs to 0, state to SEARCH, and all counters and flags to 0, regardless of vin_clk_i.
REQ-032 SHALL, on rst_n assertion mid-frame, discard the partial frame and require a full new vs-to-vs frame before the next frame_done_o pulse.

Verification
REQ-033 SHALL cover this scenario: 1080p timing (2200x1125, HA=1920, VA=1080) for 6 frames gives first frame_done_o at the second vs rise, locked_o rising at the fifth vs rise, and outputs 1920/1080/2200.
REQ-034 SHALL cover this scenario: while locked, one frame has line 500 with 1919 DE cycles, giving locked_o low at that frame's end, err_o=1, then relock after 4 clean frames.
REQ-035 SHALL cover this scenario: 720p timing (1650x750, 1280x720) gives outputs 1280/720/1650 with locked_o staying 0 and err_o staying 0.
REQ-036 SHALL cover this scenario: CW=8 with 300-cycle lines gives h_total_o=255 and err_o=1.
REQ-037 SHALL cover this scenario: rst_n pulsed low for 3 cycles at line 400 gives all outputs 0 immediately and no frame_done_o pulse until the second vs rise after release.
REQ-038 SHALL cover this scenario: vs_i held low indefinitely after lock with CW=6 gives locked_o=0 at 4096 cycles after the last vs rise.

Source files
------------

// File: rtl/vid_timing_if.sv
// Video timing monitor bundle: the raw sync/enable inputs and the measured
// geometry and status coming back out.
//   vs_i, hs_i, de_i                     : vertical sync, horizontal sync, data enable
//   h_active_o, v_active_o, h_total_o    : measured geometry of the last completed frame
//   frame_done_o, locked_o, err_o        : update pulse, lock status, sticky error
// master = video source / observer, slave = the monitor.
interface vid_timing_if #(
    parameter int CW = 12
);
    logic          vs_i;
    logic          hs_i;
    logic          de_i;
    logic [CW-1:0] h_active_o;
    logic [CW-1:0] v_active_o;
    logic [CW-1:0] h_total_o;
    logic          frame_done_o;
    logic          locked_o;
    logic          err_o;

    modport master (
        output vs_i, hs_i, de_i,
        input  h_active_o, v_active_o, h_total_o, frame_done_o, locked_o, err_o
    );

    modport slave (
        input  vs_i, hs_i, de_i,
        output h_active_o, v_active_o, h_total_o, frame_done_o, locked_o, err_o
    );
endinterface

// File: rtl/vid_timing_monitor.sv
// Video timing monitor. Measures active pixels per line, active lines per
// frame and total line length from pre-registered vs/hs/de, and declares lock
// once STABLE_FRAMES consecutive frames match EXP_HA x EXP_VA.
// Ports:
//   vin_clk_i : pixel clock, rising edge
//   rst_n     : asynchronous active-low reset
//   vid       : vid_timing_if slave (sync inputs, measurement/status outputs)
//
// state   | meaning
// --------+-----------------------------------------------------------
// SEARCH  | idle, counters held clear, waiting for the first vs rise
// MEASURE | measuring frames, no matching frame seen yet
// VERIFY  | match_q consecutive matching frames seen, not yet locked
// LOCKED  | geometry stable and equal to the expected size
module vid_timing_monitor #(
    parameter int EXP_HA        = 1920,
    parameter int EXP_VA        = 1080,
    parameter int STABLE_FRAMES = 4,
    parameter int CW            = 12
) (
    input  logic        vin_clk_i,
    input  logic        rst_n,
    vid_timing_if.slave vid
);
    localparam int            WW       = 2 * CW;
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] EXP_HA_C = CW'(EXP_HA);
    localparam logic [CW-1:0] EXP_VA_C = CW'(EXP_VA);
    localparam logic [3:0]    STABLE_C = 4'(STABLE_FRAMES);

    typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

    state_t        state_q, state_d;
    logic [3:0]    match_q, match_d, match_inc;

    logic          vs_q, hs_q, de_q;
    logic          vs_rise, hs_rise, de_fall;
    logic [CW-1:0] h_cnt, h_tot_m, de_cnt, line_len, l_cnt;
    logic          first_run, prev_valid, inc, frame_end;
    logic [WW-1:0] wd_cnt;
    logic [CW-1:0] h_active_q, v_active_q, h_total_q;
    logic          frame_done_q, err_q;
    logic          len_mismatch, sat_hit, frame_match, wd_expired;

    assign vs_rise      = vid.vs_i & ~vs_q;
    assign hs_rise      = vid.hs_i & ~hs_q;
    assign de_fall      = ~vid.de_i & de_q;
    assign len_mismatch = de_fall && (de_cnt != '0) && prev_valid && (de_cnt != line_len);
    assign sat_hit      = (h_cnt == CNT_MAX) || (de_cnt == CNT_MAX) || (l_cnt == CNT_MAX);
    assign frame_match  = !inc && (line_len == EXP_HA_C) && (l_cnt == EXP_VA_C);
    // Watchdog is a down-counter reloaded on every vs rise; terminal count means
    // a full 2^(2*CW) cycles passed without a new frame.
    assign wd_expired   = (state_q != SEARCH) && !vs_rise && (wd_cnt == '0);
    assign match_inc    = match_q + 4'd1;

    always_ff @(posedge vin_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEARCH;
            match_q <= '0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
        end
    end

    always_comb begin
        state_d = state_q;
        match_d = match_q;
        case (state_q)
            SEARCH: begin
                match_d = '0;
                if (vs_rise) state_d = MEASURE;
            end
            MEASURE: begin
                if (frame_end && frame_match) begin
                    match_d = 4'd1;
                    if (STABLE_C <= 4'd1) state_d = LOCKED;
                    else                  state_d = VERIFY;
                end
            end
            VERIFY: begin
                if (frame_end) begin
                    if (frame_match) begin
                        match_d = match_inc;
                        if (match_inc >= STABLE_C) state_d = LOCKED;
                    end else begin
                        match_d = '0;
                        state_d = MEASURE;
                    end
                end
            end
            LOCKED: begin
                if (frame_end && !frame_match) begin
                    match_d = '0;
                    state_d = MEASURE;
                end
            end
            default: state_d = SEARCH;
        endcase
        if (wd_expired) begin
            state_d = SEARCH;
            match_d = '0;
        end
    end

    always_ff @(posedge vin_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            vs_q         <= 1'b0;
            hs_q         <= 1'b0;
            de_q         <= 1'b0;
            h_cnt        <= '0;
            h_tot_m      <= '0;
            de_cnt       <= '0;
            line_len     <= '0;
            l_cnt        <= '0;
            first_run    <= 1'b0;
            prev_valid   <= 1'b0;
            inc          <= 1'b0;
            frame_end    <= 1'b0;
            wd_cnt       <= '1;
            h_active_q   <= '0;
            v_active_q   <= '0;
            h_total_q    <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            vs_q         <= vid.vs_i;
            hs_q         <= vid.hs_i;
            de_q         <= vid.de_i;
            err_q        <= err_q | sat_hit | len_mismatch;
            frame_done_q <= frame_end;

            if (state_q == SEARCH || vs_rise) wd_cnt <= '1;
            else if (wd_cnt != '0)            wd_cnt <= wd_cnt - WW'(1);

            if (state_q == SEARCH) begin
                h_cnt      <= '0;
                h_tot_m    <= '0;
                de_cnt     <= '0;
                line_len   <= '0;
                l_cnt      <= '0;
                first_run  <= 1'b0;
                prev_valid <= 1'b0;
                inc        <= 1'b0;
                frame_end  <= 1'b0;
            end else begin
                // Frame closes one cycle after vs rise so a de fall landing on the
                // vs rise cycle is already folded into line_len/l_cnt/inc.
                frame_end <= vs_rise;

                if (hs_rise) begin
                    h_tot_m <= h_cnt;
                    h_cnt   <= CW'(1);
                end else if (h_cnt != CNT_MAX) begin
                    h_cnt <= h_cnt + CW'(1);
                end

                if (de_fall) begin
                    line_len <= de_cnt;
                    de_cnt   <= '0;
                end else if (vid.de_i && de_cnt != CNT_MAX) begin
                    de_cnt <= de_cnt + CW'(1);
                end

                // A de fall coinciding with hs rise still belongs to the old line.
                if (hs_rise)      first_run <= 1'b1;
                else if (de_fall) first_run <= 1'b0;

                if (frame_end) begin
                    h_active_q <= line_len;
                    v_active_q <= l_cnt;
                    h_total_q  <= h_tot_m;
                    l_cnt      <= (de_fall && first_run) ? CW'(1) : '0;
                    inc        <= 1'b0;
                    prev_valid <= de_fall && (de_cnt != '0);
                end else begin
                    if (de_fall && first_run && l_cnt != CNT_MAX) l_cnt <= l_cnt + CW'(1);
                    if (len_mismatch)                           inc <= 1'b1;
                    if (de_fall && de_cnt != '0)                prev_valid <= 1'b1;
                end
            end
        end
    end

    assign vid.h_active_o   = h_active_q;
    assign vid.v_active_o   = v_active_q;
    assign vid.h_total_o    = h_total_q;
    assign vid.frame_done_o = frame_done_q;
    assign vid.locked_o     = (state_q == LOCKED);
    assign vid.err_o        = err_q;
endmodule
